// File: rtl/linear_interp_if.sv
// Stream bundle for linear_interp: one signed sample per beat, valid/ready handshake.
// Latency: none, wires only.
// Backpressure: beat transfers when tvalid and tready are both high at a rising clock edge.
//
// Ports/signals: tdata  signed sample, WIDTH bits
//                tvalid producer has a beat
//                tready consumer can take the beat
interface linear_interp_if #(
  parameter int WIDTH = 16
) ();
  logic signed [WIDTH-1:0] tdata;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/linear_interp.sv
// Linear interpolator: each low-rate input sample yields 2**OSR_LOG2 output beats ramping from the previous sample.
// Latency: 1 cycle from the accepting input edge to the first output beat of a segment.
// Backpressure: one-entry look-ahead buffer; s tready = !next_valid; outputs hold while m tready is low.
//
// Ports: aclk         rising-edge clock
//        arst_n       synchronous active-low reset
//        s_axis_data  slave stream, low-rate signed input samples
//        m_axis_data  master stream, registered interpolated samples
// Optional feature: define LINEAR_INTERP_UNDERFLOW_HOLD_EN to repeat the last sample on
// input underflow instead of dropping m tvalid.
module linear_interp #(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 4
) (
  input  logic            aclk,
  input  logic            arst_n,
  linear_interp_if.slave  s_axis_data,
  linear_interp_if.master m_axis_data
);

  localparam int ACC_W = WIDTH + OSR_LOG2 + 1;
  localparam int DW    = WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
`ifdef LINEAR_INTERP_UNDERFLOW_HOLD_EN
    ,
    ST_HOLD = 2'd2
`endif
  } state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] x_prev, x_cur, nxt_dat, m_dat;
  logic signed [DW-1:0]    delta;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic [OSR_LOG2-1:0]     k;
  logic                    next_valid, m_vld;

  logic in_hs, out_hs, k_last;
  logic load_seg, load_from_nxt, step, seg_end, nxt_wr, drop_vld, hold_out;
  logic signed [WIDTH-1:0] seg_base, seg_src;

  assign s_axis_data.tready = ~next_valid;
  assign m_axis_data.tdata  = m_dat;
  assign m_axis_data.tvalid = m_vld;

  assign in_hs  = s_axis_data.tvalid & ~next_valid;
  assign out_hs = m_vld & m_axis_data.tready;
  assign k_last = &k;

  // A segment chained at the end of the previous one starts from x_cur, which becomes
  // x_prev on that same edge; otherwise x_prev is already up to date.
  assign seg_base = seg_end ? x_cur : x_prev;
  assign seg_src  = load_from_nxt ? nxt_dat : s_axis_data.tdata;

  // acc carries x_prev*OSR + k*delta; it always lies between the two endpoints scaled
  // by OSR, so the extra sign bit is enough to avoid wrap on full-scale swings.
  assign acc_sum = acc + ACC_W'(delta);

  always_ff @(posedge aclk) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load_seg      = 1'b0;
    load_from_nxt = 1'b0;
    step          = 1'b0;
    seg_end       = 1'b0;
    nxt_wr        = 1'b0;
    drop_vld      = 1'b0;
    hold_out      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (next_valid) begin
          load_seg      = 1'b1;
          load_from_nxt = 1'b1;
          state_nxt     = ST_RUN;
        end else if (in_hs) begin
          load_seg  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // While a segment plays, new samples always park in the buffer, even when
        // they arrive on the last phase.
        nxt_wr = in_hs;
        if (out_hs) begin
          if (!k_last) begin
            step = 1'b1;
          end else begin
            seg_end = 1'b1;
            if (next_valid) begin
              load_seg      = 1'b1;
              load_from_nxt = 1'b1;
            end else begin
`ifdef LINEAR_INTERP_UNDERFLOW_HOLD_EN
              state_nxt = ST_HOLD;
              hold_out  = 1'b1;
`else
              state_nxt = ST_IDLE;
              drop_vld  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef LINEAR_INTERP_UNDERFLOW_HOLD_EN
      ST_HOLD: begin
        // The held beat must be taken before a buffered sample starts its segment;
        // a fresh input can start immediately since its first beat repeats x_prev.
        if (out_hs && next_valid) begin
          load_seg      = 1'b1;
          load_from_nxt = 1'b1;
          state_nxt     = ST_RUN;
        end else if (in_hs) begin
          load_seg  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      x_prev     <= '0;
      x_cur      <= '0;
      delta      <= '0;
      acc        <= '0;
      k          <= '0;
      nxt_dat    <= '0;
      next_valid <= 1'b0;
      m_dat      <= '0;
      m_vld      <= 1'b0;
    end else begin
      if (seg_end) x_prev <= x_cur;

      if (load_seg) begin
        x_cur <= seg_src;
        delta <= DW'(seg_src) - DW'(seg_base);
        acc   <= ACC_W'(seg_base) <<< OSR_LOG2;
        k     <= '0;
        m_dat <= seg_base;
        m_vld <= 1'b1;
      end else if (step) begin
        acc   <= acc_sum;
        k     <= k + OSR_LOG2'(1);
        // Dropping the low bits of a two's complement value is a floor division by OSR.
        m_dat <= acc_sum[OSR_LOG2 +: WIDTH];
      end else if (hold_out) begin
        m_dat <= x_cur;
      end else if (drop_vld) begin
        m_vld <= 1'b0;
      end

      if (load_seg && load_from_nxt) begin
        next_valid <= 1'b0;
      end else if (nxt_wr) begin
        nxt_dat    <= s_axis_data.tdata;
        next_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_linear_interp.sv
// Self-checking bench for linear_interp with WIDTH=16, OSR_LOG2=2.
// Directed vectors for the worked examples, a stall, a mid-segment reset, then random traffic.
// Every output beat is checked against an ideal interpolation model built from accepted inputs.
module tb_linear_interp;

  localparam int WIDTH    = 16;
  localparam int OSR_LOG2 = 2;
  localparam int OSR      = 1 << OSR_LOG2;

  logic aclk = 1'b0;
  logic arst_n;

  always #5 aclk = ~aclk;

  linear_interp_if #(.WIDTH(WIDTH)) s_if ();
  linear_interp_if #(.WIDTH(WIDTH)) m_if ();

  linear_interp #(.WIDTH(WIDTH), .OSR_LOG2(OSR_LOG2)) dut (
    .aclk        (aclk),
    .arst_n      (arst_n),
    .s_axis_data (s_if),
    .m_axis_data (m_if)
  );

  int      checks = 0;
  int      errors = 0;
  longint  exp_q[$];
  longint  obs[$];
  longint  prev = 0;
  bit      popped_last;
  bit      rand_done;

  int     dir_in[7]   = '{400, 400, -400, 0, 3, 32767, -32768};
  longint dir_exp[28] = '{0, 100, 200, 300,   400, 400, 400, 400,
                          400, 200, 0, -200,  -400, -300, -200, -100,
                          0, 0, 1, 2,         3, 8194, 16385, 24576,
                          32767, 16383, -1, -16385};
  longint rst_exp[4]  = '{0, 200, 400, 600};

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Ideal ramp: OSR points from p towards x, each floored to an integer.
  task automatic push_segment(input longint p, input longint x);
    for (int j = 0; j < OSR; j++) exp_q.push_back(p + floor_div(j * (x - p), OSR));
  endtask

  // Observe both handshakes half a cycle before the edge that completes them.
  always @(negedge aclk) begin
    if (arst_n !== 1'b1) begin
      exp_q.delete();
      prev = 0;
    end else begin
      popped_last = 1'b0;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        if (exp_q.size() > 0) begin
          check_val("beat", m_if.tdata, exp_q.pop_front());
          popped_last = (exp_q.size() == 0);
        end else begin
`ifdef LINEAR_INTERP_UNDERFLOW_HOLD_EN
          check_val("hold_beat", m_if.tdata, prev);
`else
          check_val("spurious_beat", m_if.tvalid, 0);
`endif
        end
        obs.push_back(m_if.tdata);
      end
      if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) begin
`ifdef LINEAR_INTERP_UNDERFLOW_HOLD_EN
        // A sample landing on the last beat of a segment is parked, so one held beat
        // of the old endpoint precedes its segment.
        if (popped_last) exp_q.push_back(prev);
`endif
        push_segment(prev, s_if.tdata);
        prev = s_if.tdata;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input int v);
    int n;
    s_if.tdata  = WIDTH'(v);
    s_if.tvalid = 1'b1;
    for (n = 0; n < 300; n++) begin
      @(negedge aclk);
      if (s_if.tready === 1'b1) break;
      tick();
    end
    if (n == 300) check_val("send_accept", s_if.tready, 1);
    tick();
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) break;
    end
    check_val("drain", exp_q.size(), 0);
    tick();
  endtask

  function automatic int rand_sample();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 65535)) - 32768;
      1:       return int'($urandom_range(0, 40)) - 20;
      2:       return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      default: return int'($urandom_range(0, 2000)) - 1000;
    endcase
  endfunction

  initial begin
    longint v0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    arst_n      = 1'b0;
    repeat (3) tick();
    arst_n = 1'b1;

    @(negedge aclk);
    check_val("rst_m_tvalid", m_if.tvalid, 0);
    check_val("rst_m_tdata", m_if.tdata, 0);
    check_val("rst_s_tready", s_if.tready, 1);
    tick();

    // Worked examples back to back, downstream always ready.
    m_if.tready = 1'b1;
    obs.delete();
    foreach (dir_in[i]) send(dir_in[i]);
    wait_drain(100);
    repeat (4) tick();
    @(negedge aclk);
`ifdef LINEAR_INTERP_UNDERFLOW_HOLD_EN
    check_val("underflow_tvalid", m_if.tvalid, 1);
    check_val("underflow_tdata", m_if.tdata, -32768);
    check_val("dir_count_min", (obs.size() >= 28) ? 1 : 0, 1);
`else
    check_val("underflow_tvalid", m_if.tvalid, 0);
    check_val("dir_count", obs.size(), 28);
`endif
    tick();
    for (int i = 0; i < 28; i++)
      if (i < obs.size()) check_val("dir_beat", obs[i], dir_exp[i]);

    // Stall mid-segment with the buffer filled.
    send(100);
    tick();
    m_if.tready = 1'b0;
    @(negedge aclk);
    v0 = m_if.tdata;
    tick();
    send(-100);
    repeat (5) begin
      @(negedge aclk);
      check_val("stall_tdata", m_if.tdata, v0);
      check_val("stall_tvalid", m_if.tvalid, 1);
      check_val("stall_s_tready", s_if.tready, 0);
      tick();
    end
    m_if.tready = 1'b1;
    wait_drain(100);

    // Reset at k=2 with the buffer full, then restart from zero.
    m_if.tready = 1'b0;
    send(1000);
    send(2000);
    m_if.tready = 1'b1;
    tick();
    tick();
    m_if.tready = 1'b0;
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    @(negedge aclk);
    check_val("post_rst_m_tvalid", m_if.tvalid, 0);
    check_val("post_rst_s_tready", s_if.tready, 1);
    check_val("post_rst_m_tdata", m_if.tdata, 0);
    tick();
    obs.delete();
    m_if.tready = 1'b1;
    send(800);
    wait_drain(100);
    if (obs.size() < 4) check_val("post_rst_count", obs.size(), 4);
    else for (int i = 0; i < 4; i++) check_val("post_rst_beat", obs[i], rst_exp[i]);

    // Random samples, gaps and downstream backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          repeat ($urandom_range(0, 5)) tick();
          send(rand_sample());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          m_if.tready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    m_if.tready = 1'b1;
    wait_drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/linear_interp.md
LINEAR_INTERP -- requirements
Module: linear_interp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter OSR_LOG2, default 4, log2 of interpolation ratio OSR = 2**OSR_LOG2; legal range 1..8.
REQ-003 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_axis_data_tdata  input  WIDTH  signed input sample, low rate.
REQ-006 SHALL have port s_axis_data_tvalid  input  1  input sample valid.
REQ-007 SHALL have port s_axis_data_tready  output  1  input ready; equals NOT next_valid, combinational.
REQ-008 SHALL have port m_axis_data_tdata  output  WIDTH  signed interpolated sample to modulator, registered.
REQ-009 SHALL have port m_axis_data_tvalid  output  1  output valid, registered.
REQ-010 SHALL have port m_axis_data_tready  input  1  downstream ready.

Function
REQ-011 SHALL hold internal state: x_prev, x_cur (WIDTH), delta (WIDTH+1, = x_cur - x_prev), acc (WIDTH+OSR_LOG2+1), phase counter k (OSR_LOG2 bits), one-entry buffer nxt with flag next_valid, FSM state IDLE/RUN (plus HOLD, REQ-024).
REQ-012 SHALL accept an input beat on s_tvalid AND s_tready; in RUN, or in IDLE with next_valid=0 blocked by nothing else, the beat loads the buffer, except REQ-013.
REQ-013 In IDLE with next_valid=0, an input handshake SHALL load a segment directly (bypass buffer).
REQ-014 Loading a segment from sample x SHALL set x_cur=x, delta=x-x_prev, acc=x_prev<<OSR_LOG2, k=0, m_tdata=x_prev, m_tvalid=1, state=RUN, on the edge after the accepting cycle (latency 1 cycle).
REQ-015 In IDLE with next_valid=1, SHALL load a segment from nxt on the next edge and clear next_valid.
REQ-016 On an output handshake in RUN with k<OSR-1: acc+=delta, k+=1, m_tdata = (acc+delta) arithmetic-shifted right by OSR_LOG2 (truncation toward minus infinity).
REQ-017 On an output handshake in RUN with k=OSR-1: x_prev=x_cur; if next_valid, load segment from nxt (REQ-014) and clear next_valid in the same edge; else underflow (REQ-024/025).
REQ-018 Input beat and last-phase output beat in the same cycle with next_valid=0: sample SHALL go to nxt; segment ends into underflow; next edge loads it per REQ-015 (or HOLD equivalent).
REQ-019 While m_tvalid=1 and m_tready=0, m_tdata, acc, k SHALL be held stable.
REQ-020 Each input sample SHALL yield exactly OSR output beats; values lie between x_prev and x_cur inclusive; no overflow for any WIDTH-bit inputs.
REQ-021 Sustained throughput: one output beat per cycle while m_tready=1 and input keeps nxt filled.

Reset
REQ-022 On arst_n=0 at a rising edge: state=IDLE, m_tvalid=0, m_tdata=0, x_prev=0, x_cur=0, delta=0, acc=0, k=0, next_valid=0; s_tready=1 after reset.
REQ-023 Reset mid-segment SHALL discard buffered and in-flight samples; first segment after reset starts from x_prev=0.

Configuration
REQ-024 With macro LINEAR_INTERP_UNDERFLOW_HOLD_EN defined: underflow SHALL enter HOLD: m_tvalid=1, m_tdata=x_prev repeated per handshake; on an output handshake with next_valid=1 (or input handshake in HOLD, which loads directly) load segment per REQ-014; output stream never gaps after first sample.
REQ-025 Without the macro: underflow SHALL enter IDLE with m_tvalid=0 on the following edge; HOLD state absent.

Verification
REQ-026 WIDTH=16, OSR_LOG2=2, m_tready=1, after reset send 400 -> outputs 0,100,200,300; then 400 arrives in time -> next segment starts at 400.
REQ-027 Segment 400 -> -400 -> outputs 400,200,0,-200; segment 0 -> 3 -> outputs 0,0,1,2 (truncation).
REQ-028 Full scale 32767 -> -32768 -> outputs 32767,16383,-1,-16385 (delta -65535, no wrap).
REQ-029 Drop m_tready for 5 cycles mid-segment -> m_tdata/m_tvalid unchanged, no beat lost, s_tready=0 once nxt full.
REQ-030 Withhold input after one segment -> without macro m_tvalid=0 after 4 beats; with LINEAR_INTERP_UNDERFLOW_HOLD_EN, m_tvalid stays 1 and m_tdata repeats last sample.
REQ-031 Assert arst_n=0 for 1 cycle at k=2 with nxt full -> m_tvalid=0, s_tready=1 next cycle; new sample 800 -> outputs 0,200,400,600.
